// File: rtl/writeback_mem_responder.sv
// Memory-side receiver for cache write-backs: acks each posted block write once,
// queues it in a small show-ahead FIFO and drains it to memory via valid/ready.
module writeback_mem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int FIFO_DEPTH    = 4,
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE),
    localparam int PTR_WIDTH    = $clog2(FIFO_DEPTH),
    localparam int COUNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     readyToSend,
    input  logic [ADDRESS_WIDTH-1:0] w_address,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    output logic                     ack,
    output logic                     mem_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     mem_ready,
    output logic [COUNT_WIDTH-1:0]   fifo_count,
    output logic                     align_err,
    input  logic                     err_clear
);

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

    rx_state_t               r_state;
    logic                    r_ack;
    logic [PTR_WIDTH-1:0]    r_wr_ptr;
    logic [PTR_WIDTH-1:0]    r_rd_ptr;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_align_err;

    logic [ADDRESS_WIDTH-1:0] r_entry_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_entry_data [FIFO_DEPTH];

    logic w_full;
    logic w_not_empty;
    logic w_push;
    logic w_pop;
    logic w_misaligned;

    assign w_full       = (r_count == COUNT_WIDTH'(FIFO_DEPTH));
    assign w_not_empty  = (r_count != '0);
    // Fullness is judged on the registered count, so a pop in the same cycle
    // never frees room for a push until the following cycle.
    assign w_push       = (r_state == RX_IDLE) && readyToSend && !w_full;
    assign w_pop        = w_not_empty && mem_ready;
    assign w_misaligned = |w_address[OFFSET_WIDTH-1:0];

    // Receive handshake: the ack cycle swallows the still-high readyToSend.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RX_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_push) begin
                        r_state <= RX_ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_ack   <= 1'b0;
                    end
                end
                RX_ACK: begin
                    r_state <= RX_IDLE;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - COUNT_WIDTH'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_entry_addr[gi] <= '0;
                    r_entry_data[gi] <= '0;
                end else if (w_push && (r_wr_ptr == PTR_WIDTH'(gi))) begin
                    r_entry_addr[gi] <= w_address;
                    r_entry_data[gi] <= dataIn;
                end
            end
        end
    endgenerate

    // Clear first, then set, so a coincident misaligned push keeps the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_align_err <= 1'b0;
        end else begin
            if (err_clear) begin
                r_align_err <= 1'b0;
            end
            if (w_push && w_misaligned) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign ack        = r_ack;
    assign mem_valid  = w_not_empty;
    assign mem_addr   = w_not_empty ? r_entry_addr[r_rd_ptr] : '0;
    assign mem_data   = w_not_empty ? r_entry_data[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign align_err  = r_align_err;

endmodule

// File: tb/tb_writeback_mem_responder.sv
// Directed bench for writeback_mem_responder: handshake, fill/stall, wrap,
// alignment flag, duplicate guard and mid-drain reset.
module tb_writeback_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        readyToSend;
    logic [31:0] w_address;
    logic [31:0] dataIn;
    logic        ack;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [2:0]  fifo_count;
    logic        align_err;
    logic        err_clear;

    int errors = 0;
    int checks = 0;
    bit toggle_ready = 1'b0;
    logic [63:0] got_q[$];

    writeback_mem_responder #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .BLOCK_SIZE(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .readyToSend(readyToSend),
        .w_address(w_address), .dataIn(dataIn), .ack(ack),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .fifo_count(fifo_count),
        .align_err(align_err), .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: record every accepted head entry.
    always @(posedge clk) begin
        if (reset_n && mem_valid && mem_ready) begin
            got_q.push_back({mem_addr, mem_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Post one write and return at the negedge where ack is seen.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit hold);
        int n;
        readyToSend = 1'b1;
        w_address   = a;
        dataIn      = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (toggle_ready) mem_ready = ~mem_ready;
        end while (!ack && n < 20);
        check("ack_seen", 64'(ack), 64'(1));
        if (!hold) readyToSend = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (fifo_count != 3'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(fifo_count), 64'(0));
    endtask

    initial begin
        int base;
        int pops;
        bit acked;

        reset_n = 1'b0; readyToSend = 1'b0; w_address = '0; dataIn = '0;
        mem_ready = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_valid", 64'(mem_valid), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_data", 64'(mem_data), 64'(0));
        check("rst_count", 64'(fifo_count), 64'(0));
        check("rst_align", 64'(align_err), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single write, ack and head visible one cycle after capture
        base = got_q.size();
        readyToSend = 1'b1; w_address = 32'h0000_1000; dataIn = 32'hDEAD_BEEF; mem_ready = 1'b1;
        @(negedge clk);
        check("t1_ack", 64'(ack), 64'(1));
        check("t1_valid", 64'(mem_valid), 64'(1));
        check("t1_addr", 64'(mem_addr), 64'h1000);
        check("t1_data", 64'(mem_data), 64'hDEAD_BEEF);
        check("t1_count1", 64'(fifo_count), 64'(1));
        readyToSend = 1'b0;
        @(negedge clk);
        check("t1_ack_drop", 64'(ack), 64'(0));
        check("t1_count0", 64'(fifo_count), 64'(0));
        check("t1_valid0", 64'(mem_valid), 64'(0));
        check("t1_addr0", 64'(mem_addr), 64'(0));
        check("t1_mem", got_q.size() > base ? got_q[base] : 64'(0), {32'h1000, 32'hDEAD_BEEF});

        // 2: fill to full, fifth request stalls until the first pop
        base = got_q.size();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h2000 + 32'(i * 32), 32'hA0 + 32'(i), 1'b0);
        check("t2_full", 64'(fifo_count), 64'(4));
        readyToSend = 1'b1; w_address = 32'h2080; dataIn = 32'hA4;
        acked = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acked = 1'b1;
        end
        check("t2_no_ack", 64'(acked), 64'(0));
        check("t2_still_full", 64'(fifo_count), 64'(4));
        mem_ready = 1'b1;
        send(32'h2080, 32'hA4, 1'b0);
        pops = got_q.size() - base;
        check("t2_pops_at_ack", 64'(pops), 64'(2));
        check("t2_count_at_ack", 64'(fifo_count), 64'(3));
        wait_empty();
        check("t2_total", 64'(got_q.size() - base), 64'(5));
        for (int i = 0; i < 5; i++)
            check("t2_order", got_q.size() > base + i ? got_q[base + i] : 64'(0),
                  {32'h2000 + 32'(i * 32), 32'hA0 + 32'(i)});

        // 3: ten writes through the ring with a toggling memory
        base = got_q.size();
        mem_ready = 1'b0;
        toggle_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h3000 + 32'(i * 32), 32'(i), 1'b0);
        toggle_ready = 1'b0;
        mem_ready = 1'b1;
        wait_empty();
        check("t3_total", 64'(got_q.size() - base), 64'(10));
        for (int i = 0; i < 10; i++)
            check("t3_order", got_q.size() > base + i ? got_q[base + i] : 64'(0),
                  {32'h3000 + 32'(i * 32), 32'(i)});

        // 4: misaligned address sets the sticky flag; clear vs. set priority
        base = got_q.size();
        mem_ready = 1'b0;
        send(32'h0000_1004, 32'h55, 1'b0);
        check("t4_align_set", 64'(align_err), 64'(1));
        check("t4_addr_kept", 64'(mem_addr), 64'h1004);
        repeat (2) @(negedge clk);
        check("t4_sticky", 64'(align_err), 64'(1));
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t4_cleared", 64'(align_err), 64'(0));
        readyToSend = 1'b1; w_address = 32'h1048; dataIn = 32'h77; err_clear = 1'b1;
        @(negedge clk);
        check("t4_prio_ack", 64'(ack), 64'(1));
        check("t4_set_wins", 64'(align_err), 64'(1));
        readyToSend = 1'b0; err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t4_cleared2", 64'(align_err), 64'(0));
        send(32'h1060, 32'h88, 1'b0);
        check("t4_aligned_no_set", 64'(align_err), 64'(0));
        check("t4_count", 64'(fifo_count), 64'(3));
        mem_ready = 1'b1;
        wait_empty();
        check("t4_e0", got_q.size() > base ? got_q[base] : 64'(0), {32'h1004, 32'h55});
        check("t4_e1", got_q.size() > base + 1 ? got_q[base + 1] : 64'(0), {32'h1048, 32'h77});
        check("t4_e2", got_q.size() > base + 2 ? got_q[base + 2] : 64'(0), {32'h1060, 32'h88});

        // 5: sender holds readyToSend through the ack cycle
        mem_ready = 1'b0;
        send(32'h5000, 32'h5A, 1'b1);
        @(negedge clk);
        check("t5_ack_once", 64'(ack), 64'(0));
        readyToSend = 1'b0;
        check("t5_count1", 64'(fifo_count), 64'(1));
        repeat (2) @(negedge clk);
        check("t5_count_stable", 64'(fifo_count), 64'(1));

        // 6: asynchronous reset with three entries queued
        send(32'h6024, 32'h61, 1'b0);
        send(32'h6040, 32'h62, 1'b0);
        @(negedge clk);
        check("t6_count3", 64'(fifo_count), 64'(3));
        check("t6_align_pre", 64'(align_err), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_ack", 64'(ack), 64'(0));
        check("t6_rst_valid", 64'(mem_valid), 64'(0));
        check("t6_rst_addr", 64'(mem_addr), 64'(0));
        check("t6_rst_data", 64'(mem_data), 64'(0));
        check("t6_rst_count", 64'(fifo_count), 64'(0));
        check("t6_rst_align", 64'(align_err), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base = got_q.size();
        mem_ready = 1'b1;
        send(32'h7000, 32'h70, 1'b0);
        check("t6_new_addr", 64'(mem_addr), 64'h7000);
        check("t6_new_count", 64'(fifo_count), 64'(1));
        @(negedge clk);
        check("t6_new_drained", 64'(fifo_count), 64'(0));
        check("t6_new_mem", got_q.size() > base ? got_q[base] : 64'(0), {32'h7000, 32'h70});
        check("t6_new_total", 64'(got_q.size() - base), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
